// File: rtl/neuron_if.sv
// Handshake bundle between the previous layer, the neuron and the sigmoid.
// The neuron sits on the slave side; the driver of the neuron is the master.
interface neuron_if #(
    parameter int N = 4
);
    logic            en;
    logic            inp_stb;
    logic [8*N-1:0]  inp_dat;
    logic            inp_rdy;
    logic            res_stb;
    logic [15:0]     res_dat;
    logic            res_rdy;
    logic            err_stb;
    logic [15:0]     err_dat;
    logic            err_rdy;
    logic            fbk_stb;
    logic [16*N-1:0] fbk_dat;
    logic            fbk_rdy;

    modport master (
        output en, inp_stb, inp_dat, res_rdy,
        output err_stb, err_dat, fbk_rdy,
        input  inp_rdy, res_stb, res_dat,
        input  err_rdy, fbk_stb, fbk_dat
    );

    modport slave (
        input  en, inp_stb, inp_dat, res_rdy,
        input  err_stb, err_dat, fbk_rdy,
        output inp_rdy, res_stb, res_dat,
        output err_rdy, fbk_stb, fbk_dat
    );
endinterface

// File: rtl/neuron.sv
// Serial MAC neuron with Q8.8 weights, training update and error back-propagation.
// Define NEURON_BIAS_EN to add a bias weight driven by a constant 8'hff input.
module neuron #(
    parameter int N    = 4,
    parameter int RATE = 0
) (
    input logic     clk,
    input logic     rst,
    neuron_if.slave bus
);
`ifdef NEURON_BIAS_EN
    localparam int K = N + 1;
`else
    localparam int K = N;
`endif
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        S_INP, S_MAC, S_RES, S_ERR, S_UPD, S_FBK
    } state_t;

    state_t state, state_nx;

    logic [IW-1:0]        idx;
    logic                 last;
    logic [8*K-1:0]       x_q;
    logic [16*K-1:0]      w_q;
    logic [16*N-1:0]      fbk_q;
    logic signed [31:0]   acc;
    logic signed [15:0]   err;
    logic signed [15:0]   res_q;
    logic signed [15:0]   wcur;
    logic signed [8:0]    xcur;
    logic signed [39:0]   acc_nx;
    logic signed [39:0]   dlt_w;
    logic signed [39:0]   w_nx;

    function automatic logic signed [15:0] sat16(
        input logic signed [39:0] v
    );
        if (v > 40'sd32767)
            return 16'sh7fff;
        else if (v < -40'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    assign last = (idx == IW'(K - 1));

    always_comb begin
        wcur   = $signed(w_q[16*int'(idx) +: 16]);
        xcur   = $signed({1'b0, x_q[8*int'(idx) +: 8]});
        acc_nx = 40'(acc) + 40'(wcur) * 40'(xcur);
        // Delta must see the weight before this cycle's update.
        dlt_w  = (40'(err) * 40'(wcur)) >>> 8;
        w_nx   = 40'(wcur)
               - ((40'(err) * 40'(xcur)) >>> (8 + RATE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_INP;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        bus.inp_rdy = 1'b0;
        bus.err_rdy = 1'b0;
        bus.res_stb = 1'b0;
        bus.fbk_stb = 1'b0;
        unique case (state)
            S_INP: begin
                bus.inp_rdy = 1'b1;
                if (bus.inp_stb)
                    state_nx = S_MAC;
            end
            S_MAC: begin
                if (last)
                    state_nx = S_RES;
            end
            S_RES: begin
                bus.res_stb = 1'b1;
                if (bus.res_rdy)
                    state_nx = bus.en ? S_ERR : S_INP;
            end
            S_ERR: begin
                bus.err_rdy = 1'b1;
                if (bus.err_stb)
                    state_nx = S_UPD;
            end
            S_UPD: begin
                if (last)
                    state_nx = S_FBK;
            end
            S_FBK: begin
                bus.fbk_stb = 1'b1;
                if (bus.fbk_rdy)
                    state_nx = S_INP;
            end
            default: state_nx = state_t'('x);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            x_q   <= '0;
            w_q   <= '0;
            fbk_q <= '0;
            acc   <= '0;
            err   <= '0;
            res_q <= '0;
        end else begin
            unique case (state)
                S_INP: begin
                    if (bus.inp_stb) begin
`ifdef NEURON_BIAS_EN
                        x_q <= {8'hff, bus.inp_dat};
`else
                        x_q <= bus.inp_dat;
`endif
                        acc <= '0;
                        idx <= '0;
                    end
                end
                S_MAC: begin
                    acc <= acc_nx[31:0];
                    idx <= idx + 1'b1;
                    if (last) begin
                        res_q <= sat16(acc_nx >>> 8);
                        idx   <= '0;
                    end
                end
                S_ERR: begin
                    if (bus.err_stb) begin
                        err <= bus.err_dat;
                        idx <= '0;
                    end
                end
                S_UPD: begin
                    w_q[16*int'(idx) +: 16] <= sat16(w_nx);
                    if (int'(idx) < N)
                        fbk_q[16*int'(idx) +: 16] <= sat16(dlt_w);
                    idx <= idx + 1'b1;
                    if (last)
                        idx <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.res_dat = bus.res_stb ? res_q : '0;
    assign bus.fbk_dat = bus.fbk_stb ? fbk_q : '0;

`ifndef SYNTHESIS
    a_state_known: assert property (
        @(posedge clk) disable iff (rst) !$isunknown(state)
    ) else $fatal(1, "neuron: state register unknown");
`endif
endmodule

// File: tb/tb_neuron.sv
// Bench for neuron: fixed vector table, randomized passes against a
// behavioural model, back-pressure and asynchronous-reset sequences.
module tb_neuron;
    localparam int N    = 4;
    localparam int RATE = 0;
`ifdef NEURON_BIAS_EN
    localparam int K = N + 1;
`else
    localparam int K = N;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    int   wm [K];

    neuron_if #(.N(N)) bus ();
    neuron #(.N(N), .RATE(RATE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, longint act, longint exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void chk_w(string nm, logic [16*N-1:0] act,
                                  logic [16*N-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic int sat(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < K; i++) wm[i] = 0;
    endfunction

    function automatic logic [15:0] m_res(logic [8*N-1:0] xv);
        longint s = 0;
        int xi;
        for (int i = 0; i < K; i++) begin
            xi = (i < N) ? int'(xv[8*i +: 8]) : 255;
            s += longint'(wm[i]) * xi;
        end
        return 16'(sat(s >>> 8));
    endfunction

    function automatic logic [16*N-1:0] m_train(logic [8*N-1:0] xv,
                                                logic [15:0] ev);
        logic [16*N-1:0] f = '0;
        int e = int'($signed(ev));
        int xi, old;
        for (int i = 0; i < K; i++) begin
            xi  = (i < N) ? int'(xv[8*i +: 8]) : 255;
            old = wm[i];
            if (i < N)
                f[16*i +: 16] = 16'(sat((longint'(e) * old) >>> 8));
            wm[i] = sat(old - ((longint'(e) * xi) >>> (8 + RATE)));
        end
        return f;
    endfunction

    function automatic logic sig(int s);
        case (s)
            0: return bus.inp_rdy;
            1: return bus.res_stb;
            2: return bus.err_rdy;
            default: return bus.fbk_stb;
        endcase
    endfunction

    task automatic wait_hi(int s, string nm);
        int t = 0;
        while (!sig(s) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk(nm, sig(s), 1);
    endtask

    task automatic idle();
        bus.inp_stb = 1'b0;
        bus.res_rdy = 1'b0;
        bus.err_stb = 1'b0;
        bus.fbk_rdy = 1'b0;
        bus.en      = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_clear();
    endtask

    task automatic run_pass(
        input  logic [8*N-1:0]  xv,
        input  logic            en,
        input  logic [15:0]     ev,
        input  int              rh,
        input  int              fh,
        output logic [15:0]     r,
        output logic [16*N-1:0] f
    );
        int t;
        logic [15:0] r0;
        logic [16*N-1:0] f0;
        r = '0;
        f = '0;
        bus.inp_dat = xv;
        bus.inp_stb = 1'b1;
        bus.en      = en;
        bus.err_dat = ev;
        bus.err_stb = en;
        wait_hi(0, "inp_rdy_wait");
        @(negedge clk);
        bus.inp_stb = 1'b0;
        bus.inp_dat = 8*N'($urandom);
        t = 1;
        while (!bus.res_stb && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("res_latency", t, K + 1);
        chk("err_rdy_in_res", bus.err_rdy, 0);
        r0 = bus.res_dat;
        for (int c = 0; c < rh; c++) begin
            @(negedge clk);
            chk("res_hold", {bus.res_stb, bus.res_dat}, {1'b1, r0});
            chk("inp_rdy_res", bus.inp_rdy, 0);
        end
        r = r0;
        bus.res_rdy = 1'b1;
        @(negedge clk);
        bus.res_rdy = 1'b0;
        bus.en = 1'($urandom);
        chk("res_once", bus.res_stb, 0);
        if (!en) begin
            chk("inp_rdy_next", bus.inp_rdy, 1);
        end else begin
            chk("inp_rdy_err", bus.inp_rdy, 0);
            chk("err_rdy_next", bus.err_rdy, 1);
            @(negedge clk);
            bus.err_stb = 1'b0;
            t = 1;
            while (!bus.fbk_stb && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk("fbk_latency", t, K + 1);
            f0 = bus.fbk_dat;
            for (int c = 0; c < fh; c++) begin
                @(negedge clk);
                chk("fbk_stb_hold", bus.fbk_stb, 1);
                chk_w("fbk_hold", bus.fbk_dat, f0);
                chk("inp_rdy_fbk", bus.inp_rdy, 0);
            end
            f = f0;
            bus.fbk_rdy = 1'b1;
            @(negedge clk);
            bus.fbk_rdy = 1'b0;
            chk("fbk_once", bus.fbk_stb, 0);
            chk("inp_rdy_after_fbk", bus.inp_rdy, 1);
        end
        bus.en = 1'b0;
    endtask

    task automatic check_reset_outputs(string nm);
        chk({nm, "_res_stb"}, bus.res_stb, 0);
        chk({nm, "_res_dat"}, bus.res_dat, 0);
        chk({nm, "_fbk_stb"}, bus.fbk_stb, 0);
        chk_w({nm, "_fbk_dat"}, bus.fbk_dat, '0);
    endtask

    typedef struct {
        logic        rs;
        logic [7:0]  xb;
        logic        en;
        logic [15:0] ev;
        logic [15:0] res;
        logic [15:0] fbk;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [15:0]     r, r_exp;
        logic [16*N-1:0] f, f_exp, xv;
        logic            en;
        logic [15:0]     ev;

`ifdef NEURON_BIAS_EN
        tbl[0] = '{1'b1, 8'h80, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 8'hff, 1'b1, 16'h0100, 16'h0000, 16'h0000};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 16'h0000, 16'hff01, 16'h0000};
        tbl[3] = '{1'b0, 8'hff, 1'b1, 16'h0100, 16'hfb09, 16'hff01};
`else
        tbl[0] = '{1'b1, 8'h80, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 8'hff, 1'b1, 16'h0100, 16'h0000, 16'h0000};
        tbl[2] = '{1'b0, 8'hff, 1'b0, 16'h0000, 16'hfc07, 16'h0000};
        tbl[3] = '{1'b0, 8'hff, 1'b1, 16'h0100, 16'hfc07, 16'hff01};
`endif
        tbl[4] = '{1'b1, 8'hff, 1'b1, 16'h7fff, 16'h0000, 16'h0000};
        tbl[5] = '{1'b0, 8'hff, 1'b1, 16'h7fff, 16'h8000, 16'h8000};
        tbl[6] = '{1'b0, 8'hff, 1'b0, 16'h0000, 16'h8000, 16'h0000};

        idle();
        bus.inp_dat = '0;
        bus.err_dat = '0;
        @(negedge clk);
        check_reset_outputs("por");
        chk("por_inp_rdy", bus.inp_rdy, 1);
        chk("por_err_rdy", bus.err_rdy, 0);
        do_reset();

        for (int v = 0; v < 7; v++) begin
            if (tbl[v].rs) do_reset();
            xv = {N{tbl[v].xb}};
            r_exp = m_res(xv);
            if (tbl[v].en) f_exp = m_train(xv, tbl[v].ev);
            run_pass(xv, tbl[v].en, tbl[v].ev, 0, 0, r, f);
            chk("tbl_res", r, tbl[v].res);
            if (tbl[v].en) chk_w("tbl_fbk", f, {N{tbl[v].fbk}});
        end

        do_reset();
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) xv[8*i +: 8] = 8'($urandom);
            en = 1'($urandom);
            ev = 16'($urandom);
            r_exp = m_res(xv);
            f_exp = en ? m_train(xv, ev) : '0;
            run_pass(xv, en, ev, $urandom_range(0, 3),
                     $urandom_range(0, 3), r, f);
            chk("rnd_res", r, r_exp);
            if (en) chk_w("rnd_fbk", f, f_exp);
        end

        xv = {N{8'h5a}};
        ev = 16'h1234;
        r_exp = m_res(xv);
        f_exp = m_train(xv, ev);
        run_pass(xv, 1'b1, ev, 10, 10, r, f);
        chk("bp_res", r, r_exp);
        chk_w("bp_fbk", f, f_exp);

        // Reset during the second MAC cycle of an inference.
        @(negedge clk);
        bus.inp_dat = 8*N'($urandom);
        bus.inp_stb = 1'b1;
        wait_hi(0, "mac_rst_inp");
        @(negedge clk);
        bus.inp_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mac_rst");
        @(negedge clk);
        rst = 1'b0;
        m_clear();
        #1;
        chk("mac_rst_inp_rdy", bus.inp_rdy, 1);
        @(negedge clk);
        run_pass(8*N'($urandom), 1'b0, 16'h0, 0, 0, r, f);
        chk("mac_rst_res", r, 16'h0000);

        xv = {N{8'hff}};
        void'(m_train(xv, 16'h0100));
        run_pass(xv, 1'b1, 16'h0100, 0, 0, r, f);

        // Reset during the second UPD cycle of a training pass.
        @(negedge clk);
        bus.inp_dat = {N{8'hff}};
        bus.inp_stb = 1'b1;
        bus.en = 1'b1;
        wait_hi(0, "upd_rst_inp");
        @(negedge clk);
        bus.inp_stb = 1'b0;
        wait_hi(1, "upd_rst_res");
        bus.res_rdy = 1'b1;
        @(negedge clk);
        bus.res_rdy = 1'b0;
        bus.err_dat = 16'h0100;
        bus.err_stb = 1'b1;
        wait_hi(2, "upd_rst_err");
        @(negedge clk);
        bus.err_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("upd_rst");
        chk("upd_rst_inp_rdy_in", bus.inp_rdy, 1);
        @(negedge clk);
        idle();
        rst = 1'b0;
        m_clear();
        #1;
        chk("upd_rst_inp_rdy", bus.inp_rdy, 1);
        @(negedge clk);
        run_pass(8*N'($urandom), 1'b0, 16'h0, 0, 0, r, f);
        chk("upd_rst_res", r, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/neuron.md
Name: neuron

Overview:
- Weighted-sum stage that sits directly upstream of the sigmoid activation stage.
- Accepts a vector of N unsigned 8-bit activations from the previous layer and computes the dot product with internal signed Q8.8 weights, one MAC per cycle.
- Sends the saturated 16-bit pre-activation to the sigmoid argument port.
- When training is enabled, it accepts the sigmoid's 16-bit feedback as error, updates its weights, and returns per-input back-propagated error to the previous layer.

Parameters:
- N, 4: number of inputs; legal range 1..256.
- RATE, 0: learning-rate right-shift applied to weight updates; legal range 0..7.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  training enable; sampled at the result handshake.
- inp_stb  in  1  input vector valid.
- inp_dat  in  8*N  activations; x[i] = inp_dat[8i+7:8i], unsigned Q0.8.
- inp_rdy  out  1  input ready.
- res_stb  out  1  result valid (to sigmoid arg_stb).
- res_dat  out  16  pre-activation, signed Q8.8.
- res_rdy  in  1  result ready.
- err_stb  in  1  error valid (from sigmoid fbk_stb).
- err_dat  in  16  error, signed.
- err_rdy  out  1  error ready.
- fbk_stb  out  1  back-propagated error valid.
- fbk_dat  out  16*N  delta[i] = fbk_dat[16i+15:16i], signed.
- fbk_rdy  in  1  feedback ready.

Behaviour:
- Handshake rule: a transfer occurs on any cycle where stb and rdy are both 1.
- The sender holds stb and data stable until the transfer occurs.
- States and transitions:
  - INP → MAC on inp ack. The block latches x[0..N-1], clears the 32-bit signed accumulator and clears index i.
  - MAC: for N cycles, acc += w[i]*x[i] (x zero-extended, 24-bit signed product), i++. After the last term, go to RES.
  - RES: res_stb rises on the first RES cycle. res_dat = acc>>>8 (arithmetic shift), saturated to [0x8000, 0x7fff]. res_stb and res_dat hold until res_rdy. On ack, go to ERR if en=1, else INP.
  - ERR: err_rdy=1. On ack, latch the error, clear i, go to UPD.
  - UPD: N cycles, one weight per cycle:
    - delta[i] = sat16((err*w_old[i])>>>8).
    - w[i] = sat16(w_old[i] - ((err*x[i])>>>(8+RATE))).
    - The delta always uses the pre-update weight.
    - Then go to FBK.
  - FBK: fbk_stb rises on the first FBK cycle and holds all N deltas until fbk_rdy. On ack, go to INP.
- Readies: inp_rdy = (state==INP); err_rdy = (state==ERR).
- Outputs are low in every state other than their own.
- Throughput:
  - Inference: inp ack to res_stb is N+1 cycles; minimum N+2 cycles per vector.
  - Training pass: adds 2+N cycles plus the handshake waits.
- Reset, asynchronous, from any state including mid-MAC and mid-UPD:
  - state=INP, res_stb=0, fbk_stb=0, res_dat=0, fbk_dat=0, acc=0, all weights=0.
  - An in-progress update is abandoned.
- Inputs asserted outside their own state are ignored and are not lost; the sender keeps holding stb.
- en changing outside RES has no effect on the current pass.
- Unknown state: synthesis drives x. Simulation prints an error and stops.

Optional Feature:
- Macro: NEURON_BIAS_EN.
- When defined:
  - An extra weight w[N] is added, with a constant input of 8'hff.
  - MAC runs N+1 cycles and UPD updates w[N] (no delta emitted for it), so latencies grow by 1 each.
  - w[N] resets to 0.
- When undefined: no bias term; the timing is exactly as above.

Test Plan:
- Reset, N=4, RATE=0, en=0, inp all 0x80, res_rdy=1 → res_dat=0x0000; res_stb rises 5 cycles after inp ack; inp_rdy returns next cycle.
- en=1, inp all 0xff, err_dat=0x0100 → res_dat=0x0000, fbk all 0x0000; weights become 0xff01. A following inference with inp all 0xff gives res_dat=0xfc07. A second training pass with err=0x0100 gives fbk deltas all 0xff01.
- Saturation:
  - Two training passes, inp all 0xff, err=0x7fff → weights 0x8081, then saturate to 0x8000.
  - Next inp all 0xff → res_dat=0x8000.
  - Weights never wrap.
- Back-pressure: hold res_rdy=0 for 10 cycles, then fbk_rdy=0 for 10 cycles → res_dat/fbk_dat stable; inp_rdy=0 throughout; exactly one transfer each on release.
- Assert rst during cycle 2 of MAC and again during UPD → outputs 0 immediately; inp_rdy=1 after release; the next inference with any input returns 0x0000.
- With NEURON_BIAS_EN: after one training pass (inp 0xff, err 0x0100), an inference with inp all 0x00 → res_dat=0xff01; res_stb latency is 6 cycles.
